// File: rtl/instruction_fetch.sv
// Instruction fetch unit: FETCH/WAIT/VALID handshake against a 1-cycle synchronous RAM,
// with branch redirect and a sticky HALTED state that only reset can leave.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  input  logic        halt,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, WAIT, VALID, HALTED} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_data_q, inst_data_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        read_q;
  logic        issue;

  // A FETCH right after a read (branch taken in FETCH) idles one cycle so
  // reads are never issued back to back.
  assign issue = (state_q == FETCH) && !read_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    if (state_q != HALTED) begin
      if (halt) begin
        state_d = HALTED;
      end else if (branch_valid) begin
        state_d = FETCH;
        pc_d    = branch_target;
      end else begin
        case (state_q)
          FETCH: if (issue) state_d = WAIT;
          WAIT: begin
            inst_data_d = mem_rdata;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + 16'd1;
            state_d     = VALID;
          end
          VALID: if (inst_ready) state_d = FETCH;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      inst_data_q <= 16'h0000;
      inst_pc_q   <= 16'h0000;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      read_q      <= issue;
    end
  end

  // Reads are masked while reset is held so the bus idles at zero until the
  // first cycle with reset low, which then fetches RESET_PC immediately.
  assign mem_read    = issue && !reset;
  assign mem_address = mem_read ? pc_q : 16'h0000;
  assign inst_valid  = (state_q == VALID);
  assign inst_data   = inst_data_q;
  assign inst_pc     = inst_pc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_address  output  16  instruction memory word address, registered.
REQ-005 mem_read  output  1  read request; high for exactly the cycle mem_address is being fetched.
REQ-006 mem_rdata  input  16  memory read data; valid the cycle after mem_read high (1-cycle synchronous RAM).
REQ-007 branch_valid  input  1  controller requests redirect this cycle.
REQ-008 branch_target  input  16  redirect address, sampled when branch_valid high.
REQ-009 halt  input  1  controller decoded HALT; stop fetching.
REQ-010 inst_valid  output  1  inst_data/inst_pc hold an instruction for the controller.
REQ-011 inst_data  output  16  fetched instruction word, feeds the instruction register.
REQ-012 inst_pc  output  16  word address of inst_data.
REQ-013 inst_ready  input  1  controller accepts inst_data when inst_valid and inst_ready both high.
REQ-014 halted  output  1  high while in HALTED state.

Function
REQ-015 FSM states SHALL be FETCH, WAIT, VALID, HALTED; exactly one active per cycle.
REQ-016 FETCH: mem_read=1, mem_address=pc; next state WAIT.
REQ-017 WAIT: mem_read=0; capture mem_rdata into inst_data, pc into inst_pc, pc <= pc+1; next state VALID.
REQ-018 VALID: inst_valid=1, inst_data/inst_pc stable; stay until inst_ready=1, then next state FETCH.
REQ-019 Latency: mem_read in cycle N -> inst_valid high from cycle N+2; peak throughput 1 instruction per 3 cycles.
REQ-020 PC increment modulo 2^16: 16'hFFFF + 1 = 16'h0000, no flag, no stall.
REQ-021 branch_valid in any non-HALTED state: pc <= branch_target, inst_valid deasserts next cycle, next state FETCH.
REQ-022 Branch in WAIT: mem_rdata that cycle discarded, inst_data not updated.
REQ-023 Branch in VALID with inst_ready=1 same cycle: held instruction counts as consumed; branch target wins over pc+1 sequence.
REQ-024 Branch in FETCH: in-flight read abandoned, its data never presented.
REQ-025 halt in any state: next state HALTED; inst_valid=0, mem_read=0, pc frozen; halt takes priority over branch_valid.
REQ-026 HALTED SHALL be left only by reset; branch_valid and inst_ready ignored.
REQ-027 Priority per cycle: reset > halt > branch_valid > normal FSM progression.
REQ-028 inst_valid SHALL never be high outside VALID; inst_data SHALL never change while inst_valid high.
REQ-029 mem_read SHALL never be high in two consecutive cycles.

Reset
REQ-030 reset high at rising edge: state <= FETCH, pc <= RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, mem_read=0, mem_address=0, halted=0.
REQ-031 First mem_read=1 with mem_address=RESET_PC occurs in first cycle after reset deasserts.
REQ-032 reset mid-operation (any state, incl. WAIT/VALID/HALTED) SHALL discard in-flight data and apply REQ-030 in that same edge.

Verification
REQ-033 Sequential fetch: memory[0..2]=16'hC00F,16'h4102,16'hC0D0, inst_ready=1 -> inst_valid with (inst_pc,inst_data)=(0,C00F),(1,4102),(2,C0D0), each 3 cycles apart.
REQ-034 Backpressure: inst_ready=0 for 5 cycles in VALID -> inst_valid held, inst_data unchanged, mem_read=0 throughout; accept on 6th -> next fetch of pc+1.
REQ-035 Branch in WAIT: branch_valid=1, branch_target=16'h0040 -> old data never presented; next inst_pc=16'h0040.
REQ-036 Wrap: RESET_PC=16'hFFFF -> inst_pc=FFFF then 0000.
REQ-037 Halt vs branch: halt=1 and branch_valid=1 same cycle -> halted=1, inst_valid=0, no further mem_read until reset.
REQ-038 Reset in VALID with inst_valid=1 -> next cycle inst_valid=0, mem_read=1, mem_address=RESET_PC.
